// File: rtl/alu.sv
// Registered 32-bit integer ALU for the RV32I execute stage.
// Produces arithmetic, logic, shift, set-less-than and branch-condition results
// selected by a 6-bit control code. It also passes operand_A through for JAL/JALR.
// The result is captured on every rising clock edge, giving one cycle of latency.
module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CTRL_WIDTH-1:0] ALU_Control,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic [DATA_WIDTH-1:0] ALU_result
);

    // Operation codes produced by the ALU control decoder.
    localparam logic [CTRL_WIDTH-1:0] OP_ADD  = 6'h00;
    localparam logic [CTRL_WIDTH-1:0] OP_SUB  = 6'h01;
    localparam logic [CTRL_WIDTH-1:0] OP_SLL  = 6'h02;
    localparam logic [CTRL_WIDTH-1:0] OP_SLT  = 6'h03;
    localparam logic [CTRL_WIDTH-1:0] OP_SLTU = 6'h04;
    localparam logic [CTRL_WIDTH-1:0] OP_XOR  = 6'h05;
    localparam logic [CTRL_WIDTH-1:0] OP_SRL  = 6'h06;
    localparam logic [CTRL_WIDTH-1:0] OP_SRA  = 6'h07;
    localparam logic [CTRL_WIDTH-1:0] OP_OR   = 6'h08;
    localparam logic [CTRL_WIDTH-1:0] OP_AND  = 6'h09;
    localparam logic [CTRL_WIDTH-1:0] OP_BEQ  = 6'h0A;
    localparam logic [CTRL_WIDTH-1:0] OP_BNE  = 6'h0B;
    localparam logic [CTRL_WIDTH-1:0] OP_BLT  = 6'h0C;
    localparam logic [CTRL_WIDTH-1:0] OP_BGE  = 6'h0D;
    localparam logic [CTRL_WIDTH-1:0] OP_BLTU = 6'h0E;
    localparam logic [CTRL_WIDTH-1:0] OP_BGEU = 6'h0F;
    localparam logic [CTRL_WIDTH-1:0] OP_JAL  = 6'h1F;
    localparam logic [CTRL_WIDTH-1:0] OP_JALR = 6'h3F;

    // Only the low five bits of operand_B select the shift distance.
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]  sum_w;
    logic [DATA_WIDTH-1:0]  diff_w;
    logic                   eq_w;
    logic                   lt_s_w;
    logic                   lt_u_w;
    logic [SHAMT_WIDTH-1:0] shamt_w;
    logic [DATA_WIDTH-1:0]  sll_w;
    logic [DATA_WIDTH-1:0]  srl_w;
    logic [DATA_WIDTH-1:0]  sra_w;
    logic [DATA_WIDTH-1:0]  result_d;
    logic [DATA_WIDTH-1:0]  result_q;

    // Adder and subtractor. Wrap modulo 2^DATA_WIDTH, and the carry is discarded.
    always_comb begin
        sum_w  = operand_A + operand_B;
        diff_w = operand_A - operand_B;
    end

    // Equality plus signed and unsigned less-than. All compare and branch codes use these.
    always_comb begin
        eq_w   = (operand_A == operand_B);
        lt_s_w = ($signed(operand_A) < $signed(operand_B));
        lt_u_w = (operand_A < operand_B);
    end

    // Barrel shifts. A distance of 32 wraps to 0 because only operand_B[4:0] is used.
    always_comb begin
        shamt_w = operand_B[SHAMT_WIDTH-1:0];
        sll_w   = operand_A << shamt_w;
        srl_w   = operand_A >> shamt_w;
        sra_w   = DATA_WIDTH'($signed(operand_A) >>> shamt_w);
    end

    // Result select. Any unlisted or unknown code yields zero, never X.
    always_comb begin
        result_d = '0;
        case (ALU_Control)
            OP_ADD:  result_d = sum_w;
            OP_SUB:  result_d = diff_w;
            OP_SLL:  result_d = sll_w;
            OP_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, lt_s_w};
            OP_SLTU: result_d = {{(DATA_WIDTH-1){1'b0}}, lt_u_w};
            OP_XOR:  result_d = operand_A ^ operand_B;
            OP_SRL:  result_d = srl_w;
            OP_SRA:  result_d = sra_w;
            OP_OR:   result_d = operand_A | operand_B;
            OP_AND:  result_d = operand_A & operand_B;
            OP_BEQ:  result_d = {{(DATA_WIDTH-1){1'b0}}, eq_w};
            OP_BNE:  result_d = {{(DATA_WIDTH-1){1'b0}}, ~eq_w};
            OP_BLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, lt_s_w};
            OP_BGE:  result_d = {{(DATA_WIDTH-1){1'b0}}, ~lt_s_w};
            OP_BLTU: result_d = {{(DATA_WIDTH-1){1'b0}}, lt_u_w};
            OP_BGEU: result_d = {{(DATA_WIDTH-1){1'b0}}, ~lt_u_w};
            OP_JAL:  result_d = operand_A;
            OP_JALR: result_d = operand_A;
            default: result_d = '0;
        endcase
    end

    // Output register. Reset clears it at once, and it then loads every clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign ALU_result = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU.
// The bench runs directed cases first, then a random back-to-back burst.
// A behavioural model computes each expected result using integer arithmetic.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] ALU_result;

    int checks = 0;
    int errors = 0;

    alu #(.DATA_WIDTH(32), .CTRL_WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALU_Control(ALU_Control),
        .operand_A  (operand_A),
        .operand_B  (operand_B),
        .ALU_result (ALU_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam longint M = 64'h1_0000_0000;

    // Behavioural reference. It is written as integer arithmetic on 64-bit values.
    function automatic logic [31:0] model(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ua, ub, sa, sb, p, r;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = a[31] ? ua - M : ua;
        sb = b[31] ? ub - M : ub;
        p  = longint'(1) << b[4:0];
        case (c)
            6'h00: r = (ua + ub) % M;
            6'h01: r = (ua - ub + M) % M;
            6'h02: r = (ua * p) % M;
            6'h03: r = (sa < sb) ? 1 : 0;
            6'h04: r = (ua < ub) ? 1 : 0;
            6'h05: r = longint'({32'b0, a ^ b});
            6'h06: r = ua / p;
            6'h07: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            6'h08: r = longint'({32'b0, a | b});
            6'h09: r = longint'({32'b0, a & b});
            6'h0A: r = (ua == ub) ? 1 : 0;
            6'h0B: r = (ua != ub) ? 1 : 0;
            6'h0C: r = (sa < sb) ? 1 : 0;
            6'h0D: r = (sa >= sb) ? 1 : 0;
            6'h0E: r = (ua < ub) ? 1 : 0;
            6'h0F: r = (ua >= ub) ? 1 : 0;
            6'h1F: r = ua;
            6'h3F: r = ua;
            default: r = 0;
        endcase
        r = (r % M + M) % M;
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation at negedge and check it one edge later. The expected value is given explicitly.
    task automatic step(input string tag, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        ALU_Control = c; operand_A = a; operand_B = b;
        @(posedge clk);
        #1;
        $display("txn %-10s ctrl=%h a=%h b=%h result=%h", tag, c, a, b, ALU_result);
        check(tag, ALU_result, exp);
        check({tag, "_model"}, ALU_result, model(c, a, b));
    endtask

    logic [5:0]  valid_codes [18] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                      6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                      6'h0E, 6'h0F, 6'h1F, 6'h3F};
    logic [31:0] exp_prev;
    logic [5:0]  rc;
    logic [31:0] ra, rb;

    initial begin
        rst_n = 1'b0; ALU_Control = 6'h00; operand_A = 32'd7; operand_B = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", ALU_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic and logic
        step("add",      6'h00, 32'd15, 32'd10, 32'd25);
        step("sub",      6'h01, 32'd20, 32'd5, 32'd15);
        step("sub_wrap", 6'h01, 32'd0, 32'd1, 32'hFFFF_FFFF);
        step("add_ovf",  6'h00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        step("or",       6'h08, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
        step("xor",      6'h05, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
        step("and",      6'h09, 32'h1234_5678, 32'h8765_4321, 32'h0224_4220);
        // Shifts
        step("sll",      6'h02, 32'd1, 32'd5, 32'd32);
        step("srl",      6'h06, 32'h8000_0000, 32'd1, 32'h4000_0000);
        step("sra",      6'h07, 32'h8000_0000, 32'd1, 32'hC000_0000);
        step("sll_b25",  6'h02, 32'd1, 32'h25, 32'd32);
        step("sll_32",   6'h02, 32'h0000_00F3, 32'h20, 32'h0000_00F3);
        step("sra_pos",  6'h07, 32'h4000_0000, 32'd4, 32'h0400_0000);
        // Compares
        step("slt",      6'h03, 32'd5, 32'd10, 32'd1);
        step("sltu",     6'h04, 32'd5, 32'd10, 32'd1);
        step("slt_neg",  6'h03, 32'hFFFF_FFFF, 32'd1, 32'd1);
        step("sltu_big", 6'h04, 32'hFFFF_FFFF, 32'd1, 32'd0);
        step("slt_min",  6'h03, 32'h8000_0000, 32'd1, 32'd1);
        step("sltu_min", 6'h04, 32'h8000_0000, 32'd1, 32'd0);
        // Branches
        step("beq",      6'h0A, 32'd15, 32'd15, 32'd1);
        step("beq_ne",   6'h0A, 32'd15, 32'd16, 32'd0);
        step("bne",      6'h0B, 32'd20, 32'd15, 32'd1);
        step("blt",      6'h0C, 32'd20, 32'd15, 32'd0);
        step("bge",      6'h0D, 32'd20, 32'd15, 32'd1);
        step("bge_eq",   6'h0D, 32'd15, 32'd15, 32'd1);
        step("bge_neg",  6'h0D, 32'hFFFF_FFF0, 32'd3, 32'd0);
        step("bltu",     6'h0E, 32'd1, 32'hFFFF_FFFF, 32'd1);
        step("bgeu",     6'h0F, 32'd25, 32'd20, 32'd1);
        step("bgeu_eq",  6'h0F, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1);
        // Jumps and an undefined code
        step("jal",      6'h1F, 32'd100, 32'hFFFF_0000, 32'd100);
        step("jalr",     6'h3F, 32'd200, 32'h1234_5678, 32'd200);
        step("undef10",  6'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

        // Assert reset mid-cycle while the output is nonzero. It must clear before the next edge.
        step("pre_rst",  6'h01, 32'd0, 32'd1, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", ALU_result, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held", ALU_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ALU_Control = 6'h00; operand_A = 32'd15; operand_B = 32'd10;
        @(posedge clk);
        #1;
        $display("txn %-10s ctrl=%h a=%h b=%h result=%h", "post_rst", ALU_Control,
                 operand_A, operand_B, ALU_result);
        check("post_rst_add", ALU_result, 32'd25);

        // Random back-to-back burst with a new operation every cycle.
        // Before each new drive, check that the previous result has landed.
        // Also confirm the result does not change again before the next edge.
        exp_prev = 32'd25;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check("b2b_hold", ALU_result, exp_prev);
            if ($urandom_range(9) == 0) rc = 6'($urandom);
            else rc = valid_codes[$urandom_range(17)];
            ra = $urandom;
            case ($urandom_range(3))
                0: rb = ra;
                1: rb = {27'($urandom), 5'($urandom)};
                default: rb = $urandom;
            endcase
            if ($urandom_range(7) == 0) ra = {1'b1, 31'($urandom)};
            ALU_Control = rc; operand_A = ra; operand_B = rb;
            exp_prev = model(rc, ra, rb);
            @(posedge clk);
            #1;
            $display("txn %-10s ctrl=%h a=%h b=%h result=%h", "rand", rc, ra, rb, ALU_result);
            check("rand", ALU_result, exp_prev);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU for the RV32I core's execute stage.
- Computes arithmetic, logic, shift and set-less-than results.
- Evaluates branch conditions as a 0/1 result.
- Passes the operand through for JAL/JALR.
- Operation is selected by a 6-bit control code from the ALU control decoder; the result is registered once per clock.

Parameters:
- DATA_WIDTH, 32, operand/result width; the design is only required to work at 32.
- CTRL_WIDTH, 6, width of ALU_Control.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ALU_Control  input  6  operation select (codes below)
- operand_A  input  32  first operand (rs1 or PC)
- operand_B  input  32  second operand (rs2 or immediate)
- ALU_result  output  32  registered result

Behaviour:
- rst_n low: ALU_result is cleared to 32'h0 immediately, without waiting for clk.
  - Holds 0 while rst_n is low.
  - Reset mid-operation discards the pending result.
  - Release is synchronous to the next rising clk: the first capture after release uses the inputs current at that edge.
- Latency is 1 cycle.
  - On each rising clk, ALU_result <= f(ALU_Control, operand_A, operand_B).
  - No enable and no handshake; the register updates every cycle.
  - Inputs are sampled only at the edge.
- Operation codes (hex), result f:
  - 00 ADD: A+B, modulo 2^32, carry dropped.
  - 01 SUB: A-B, modulo 2^32 (0-1 = FFFFFFFF).
  - 02 SLL: A << B[4:0].
  - 03 SLT: {31'b0, signed(A) < signed(B)}.
  - 04 SLTU: {31'b0, A < B unsigned}.
  - 05 XOR: A ^ B.
  - 06 SRL: A >> B[4:0], zero fill.
  - 07 SRA: A >>> B[4:0], sign fill.
  - 08 OR: A | B.
  - 09 AND: A & B.
  - 0A BEQ: 1 if A==B else 0.
  - 0B BNE: 1 if A!=B else 0.
  - 0C BLT: 1 if signed A<B else 0.
  - 0D BGE: 1 if signed A>=B else 0.
  - 0E BLTU: 1 if unsigned A<B else 0.
  - 0F BGEU: 1 if unsigned A>=B else 0.
  - 1F JAL: A (pass-through; operand_B ignored).
  - 3F JALR: A (pass-through; operand_B ignored).
- Any other code (including X/Z on ALU_Control): result is 32'h0. Never X.
- Shifts use only operand_B[4:0]; operand_B[31:5] are ignored, so a shift of 32 behaves as a shift of 0.
- Branch and compare results occupy bit 0 only; bits 31:1 are 0.
- Boundary cases:
  - Signed compares treat bit 31 as sign: SLT(80000000, 00000001) = 1; SLTU on the same operands = 0.
  - BGE and BGEU return 1 for equal operands.
  - Overflow is not flagged: ADD 7FFFFFFF+1 = 80000000.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ALU_result nonzero -> ALU_result = 0 before the next clk edge. Release, then ADD 15,10 -> 25 after one clk.
- Arithmetic/logic:
  - ADD 15+10 -> 25; SUB 20-5 -> 15; SUB 0-1 -> FFFFFFFF.
  - OR A5A5A5A5|5A5A5A5A -> FFFFFFFF.
  - XOR F0F0F0F0^0F0F0F0F -> FFFFFFFF.
  - AND 12345678&87654321 -> 02244220.
- Shifts:
  - SLL 1<<5 -> 32.
  - SRL 80000000>>1 -> 40000000.
  - SRA 80000000>>>1 -> C0000000.
  - SLL with B=0x25 -> shift by 5.
- Compares:
  - SLT 5,10 -> 1; SLTU 5,10 -> 1.
  - SLT FFFFFFFF,1 -> 1; SLTU FFFFFFFF,1 -> 0.
- Branches:
  - BEQ 15,15 -> 1; BNE 20,15 -> 1.
  - BLT 20,15 -> 0; BGE 20,15 -> 1; BGE 15,15 -> 1.
  - BLTU 1,FFFFFFFF -> 1; BGEU 25,20 -> 1.
- Jump/default:
  - JAL A=100 -> 100; JALR A=200 -> 200.
  - Code 0x10 -> 0; codes applied back-to-back each cycle -> each result appears exactly one clk later.
